// File: rtl/spi_mem_loader.sv
// spi_mem_loader: SPI mode-0 slave that fills a parameter/weight memory.
// The first byte of each frame is the start address, following bytes are data
// written at auto-incrementing addresses. Every received byte is echoed on MISO
// during the next byte.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   spi_sclk/mosi/cs_n  SPI pins, asynchronous to clk (sclk <= clk/8)
//   spi_miso            echo of the previous byte, MSB first
//   mem_addr/mem_data   memory write port address/data, held between writes
//   mem_we              one-cycle write strobe per accepted data byte
//   frame_done          one-cycle pulse at the end of a frame
//   addr_error          sticky: a data byte in this/last frame hit addr >= DEPTH
//   busy                a frame is in progress
module spi_mem_loader #(
  parameter int unsigned DEPTH       = 115,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_we,
  output logic       frame_done,
  output logic       addr_error,
  output logic       busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_ADDR = 2'd1;
  localparam logic [1:0] GET_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] echo;
  logic [7:0] ptr;
  logic       done_pend;

  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       in_frame, cap, byte_done, in_range;
  logic [7:0] rx_byte;

  // Input synchronisers plus one extra flop each for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s    = sclk_sync[SYNC_STAGES-1];
    mosi_s    = mosi_sync[SYNC_STAGES-1];
    cs_s      = cs_sync[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev;
    sclk_fall = ~sclk_s & sclk_prev;
    cs_rise   = cs_s & ~cs_prev;
    cs_fall   = ~cs_s & cs_prev;
    in_frame  = (state == GET_ADDR) || (state == GET_DATA);
    // Capture stays enabled in the cs_n-rise cycle so a byte finishing
    // together with the frame end is still processed.
    cap       = in_frame & sclk_rise;
    rx_byte   = {rx_shift[6:0], mosi_s};
    byte_done = cap & (bit_cnt == 3'd7);
    in_range  = 32'(ptr) < DEPTH;
  end

  assign busy     = in_frame;
  assign spi_miso = in_frame & tx_shift[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_shift   <= 8'h00;
      tx_shift   <= 8'h00;
      echo       <= 8'h00;
      ptr        <= 8'h00;
      mem_addr   <= 8'h00;
      mem_data   <= 8'h00;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      addr_error <= 1'b0;
      done_pend  <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      frame_done <= done_pend;
      done_pend  <= 1'b0;
      if (!in_frame) begin
        if (cs_fall) begin
          state      <= GET_ADDR;
          bit_cnt    <= 3'd0;
          addr_error <= 1'b0;
          echo       <= 8'h00;
          tx_shift   <= 8'h00;
        end else if (state != IDLE) begin
          state <= IDLE;
        end
      end else begin
        if (cap) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
        end else if (sclk_fall && bit_cnt != 3'd0) begin
          // The falling edge right after a byte boundary must not shift, or
          // the freshly loaded MSB would be lost before the host samples it.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end

        if (byte_done) begin
          echo     <= rx_byte;
          tx_shift <= rx_byte;
          if (state == GET_ADDR) begin
            ptr   <= rx_byte;
            state <= GET_DATA;
          end else if (in_range) begin
            mem_addr <= ptr;
            mem_data <= rx_byte;
            mem_we   <= 1'b1;
            ptr      <= ptr + 8'd1;
          end else begin
            addr_error <= 1'b1;
          end
        end

        if (cs_rise) begin
          state <= IDLE;
          // Keep frame_done after the final mem_we when both coincide.
          if (byte_done) begin
            done_pend <= 1'b1;
          end else begin
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
module tb_spi_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_we;
  logic       frame_done;
  logic       addr_error;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         fd_cnt = 0;

  always #5 clk = ~clk;

  spi_mem_loader #(
    .DEPTH      (115),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .frame_done(frame_done),
    .addr_error(addr_error),
    .busy      (busy)
  );

  // Log every write strobe cycle and frame_done cycle away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    fd_cnt = 0;
  endtask

  // sclk half-period is 8 clk cycles; all stimulus times stay on 10 ns multiples.
  task automatic spi_begin();
    spi_cs_n = 1'b0;
    #80;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      #80;
      rx[7-i] = spi_miso;
      spi_sclk = 1'b1;
      #80;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    #80;
    spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({mem_addr, mem_data} !== 16'h0000) begin
      bad++; $display("FAIL reset_addr_data got=%h want=0000", {mem_addr, mem_data});
    end
    total++;
    if ({mem_we, spi_miso, frame_done, addr_error, busy} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {mem_we, spi_miso, frame_done, addr_error, busy});
    end
    #29;
    reset = 1'b1;
    #40;
  endtask

  task automatic test_basic();
    logic [7:0] rx;
    logic [7:0] ea[2] = '{8'd0, 8'd1};
    logic [7:0] ed[2] = '{8'hA5, 8'h3C};
    clear_log();
    spi_begin();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b want=1", busy); end
    spi_byte(8'h00, 8, rx);
    spi_byte(8'hA5, 8, rx);
    spi_byte(8'h3C, 8, rx);
    spi_end();
    total++;
    if (wa.size() != 2) begin bad++; $display("FAIL basic_nwr got=%0d want=2", wa.size()); end
    for (int i = 0; i < 2 && i < wa.size(); i++) begin
      total++;
      if ({wa[i], wd[i]} !== {ea[i], ed[i]}) begin
        bad++; $display("FAIL basic_wr%0d got=%h want=%h", i, {wa[i], wd[i]}, {ea[i], ed[i]});
      end
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL basic_fd got=%0d want=1", fd_cnt); end
    total++;
    if ({addr_error, busy} !== 2'b00) begin
      bad++; $display("FAIL basic_err_busy got=%b want=00", {addr_error, busy});
    end
  endtask

  task automatic test_range();
    logic [7:0] rx;
    logic [7:0] ea[2] = '{8'd113, 8'd114};
    logic [7:0] ed[2] = '{8'h11, 8'h22};
    clear_log();
    spi_begin();
    spi_byte(8'h71, 8, rx);
    spi_byte(8'h11, 8, rx);
    spi_byte(8'h22, 8, rx);
    total++;
    if (addr_error !== 1'b0) begin bad++; $display("FAIL range_err_early got=%b want=0", addr_error); end
    spi_byte(8'h33, 8, rx);
    spi_byte(8'h44, 8, rx);
    spi_end();
    total++;
    if (wa.size() != 2) begin bad++; $display("FAIL range_nwr got=%0d want=2", wa.size()); end
    for (int i = 0; i < 2 && i < wa.size(); i++) begin
      total++;
      if ({wa[i], wd[i]} !== {ea[i], ed[i]}) begin
        bad++; $display("FAIL range_wr%0d got=%h want=%h", i, {wa[i], wd[i]}, {ea[i], ed[i]});
      end
    end
    total++;
    if (addr_error !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", addr_error); end
  endtask

  task automatic test_reject_then_clear();
    logic [7:0] rx;
    clear_log();
    spi_begin();
    spi_byte(8'h80, 8, rx);
    spi_byte(8'hFF, 8, rx);
    spi_end();
    total++;
    if (wa.size() != 0) begin bad++; $display("FAIL reject_nwr got=%0d want=0", wa.size()); end
    total++;
    if (addr_error !== 1'b1) begin bad++; $display("FAIL reject_err got=%b want=1", addr_error); end
    clear_log();
    spi_begin();
    total++;
    if (addr_error !== 1'b0) begin bad++; $display("FAIL clear_err_start got=%b want=0", addr_error); end
    spi_byte(8'h05, 8, rx);
    spi_byte(8'h77, 8, rx);
    spi_end();
    total++;
    if (wa.size() != 1) begin bad++; $display("FAIL clear_nwr got=%0d want=1", wa.size()); end
    else begin
      total++;
      if ({wa[0], wd[0]} !== 16'h0577) begin
        bad++; $display("FAIL clear_wr got=%h want=0577", {wa[0], wd[0]});
      end
    end
    total++;
    if (addr_error !== 1'b0) begin bad++; $display("FAIL clear_err_end got=%b want=0", addr_error); end
  endtask

  task automatic test_partial();
    logic [7:0] rx;
    clear_log();
    spi_begin();
    spi_byte(8'h02, 8, rx);
    spi_byte(8'h9C, 8, rx);
    spi_byte(8'hE7, 5, rx);
    spi_end();
    total++;
    if (wa.size() != 1) begin bad++; $display("FAIL partial_nwr got=%0d want=1", wa.size()); end
    else begin
      total++;
      if ({wa[0], wd[0]} !== 16'h029C) begin
        bad++; $display("FAIL partial_wr got=%h want=029c", {wa[0], wd[0]});
      end
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL partial_fd got=%0d want=1", fd_cnt); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b want=0", busy); end
  endtask

  task automatic test_miso();
    logic [7:0] r0, r1, r2;
    clear_log();
    spi_begin();
    spi_byte(8'h00, 8, r0);
    spi_byte(8'hC3, 8, r1);
    spi_byte(8'h5A, 8, r2);
    spi_end();
    total++;
    if ({r0, r1, r2} !== 24'h0000C3) begin
      bad++; $display("FAIL miso_echo got=%h want=0000c3", {r0, r1, r2});
    end
    total++;
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL miso_idle got=%b want=0", spi_miso); end
    total++;
    if (wa.size() != 2) begin bad++; $display("FAIL miso_nwr got=%0d want=2", wa.size()); end
    else begin
      total++;
      if ({wa[0], wd[0], wa[1], wd[1]} !== 32'h00C3015A) begin
        bad++; $display("FAIL miso_wr got=%h want=00c3015a", {wa[0], wd[0], wa[1], wd[1]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    clear_log();
    spi_begin();
    spi_byte(8'h20, 8, rx);
    spi_byte(8'hFF, 3, rx);
    reset = 1'b0;
    #1;
    total++;
    if ({mem_addr, mem_data} !== 16'h0000) begin
      bad++; $display("FAIL rstmid_addr_data got=%h want=0000", {mem_addr, mem_data});
    end
    total++;
    if ({mem_we, spi_miso, frame_done, addr_error, busy} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_flags got=%b want=00000",
               {mem_we, spi_miso, frame_done, addr_error, busy});
    end
    #9;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #50;
    reset = 1'b1;
    #60;
    total++;
    if (wa.size() != 0) begin bad++; $display("FAIL rstmid_nwr got=%0d want=0", wa.size()); end
    clear_log();
    spi_begin();
    spi_byte(8'h10, 8, rx);
    spi_byte(8'h42, 8, rx);
    spi_end();
    total++;
    if (wa.size() != 1) begin bad++; $display("FAIL rstpost_nwr got=%0d want=1", wa.size()); end
    else begin
      total++;
      if ({wa[0], wd[0]} !== 16'h1042) begin
        bad++; $display("FAIL rstpost_wr got=%h want=1042", {wa[0], wd[0]});
      end
    end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL rstpost_fd got=%0d want=1", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_reject_then_clear();
    test_partial();
    test_miso();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
